// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array activation feeder.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} skew_state_t;

  // Width needed to hold a drain count of 0..drain_cycles.
  function automatic int unsigned drain_cnt_w(input int unsigned drain_cycles);
    return $clog2(drain_cycles + 1);
  endfunction

endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset; output is the last stage.
module sa_delay_line #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= d_i;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[DEPTH-2:0], d_i};
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_act_skew.sv
// Activation skew feeder: delays row r by r cycles, pads bubbles with zeros and drains the
// array with zero wavefronts before pulsing completion.
module sa_act_skew
  import sa_pkg::*;
#(
  parameter int unsigned MUL_DATAWIDTH = 8,
  parameter int unsigned NUM_ROWS      = 4,
  parameter int unsigned NUM_COLS      = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DRAIN_CYCLES  = NUM_ROWS + NUM_COLS - 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_start,
  input  logic [CNT_W-1:0]                        i_num_vec,
  input  logic                                    i_act_valid,
  input  logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]  i_act,
  output logic                                    o_act_ready,
  output logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]  o_act,
  output logic [NUM_ROWS-1:0]                     o_act_vld,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int unsigned DrainCntW = drain_cnt_w(DRAIN_CYCLES);
  localparam logic [DrainCntW-1:0] DrainLoad = DrainCntW'(DRAIN_CYCLES);

  if (NUM_ROWS < 1) begin : g_chk_rows
    $fatal(1, "sa_act_skew: NUM_ROWS must be >= 1");
  end
  if (DRAIN_CYCLES < 1) begin : g_chk_drain
    $fatal(1, "sa_act_skew: DRAIN_CYCLES must be >= 1");
  end

  skew_state_t            state_q, state_d;
  logic [CNT_W-1:0]       vec_rem_q, vec_rem_d;
  logic [DrainCntW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                   done_q, done_d;
  logic                   accept;

  assign accept = i_act_valid && o_act_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_rem_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_rem_q   <= vec_rem_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_rem_d   = vec_rem_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_num_vec != '0) begin
            vec_rem_d = i_num_vec;
            state_d   = FEED;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (accept) begin
          vec_rem_d = vec_rem_q - 1'b1;
          if (vec_rem_q == CNT_W'(1)) begin
            state_d     = DRAIN;
            drain_cnt_d = DrainLoad;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == DrainCntW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_act_ready = (state_q == FEED);
    o_busy      = (state_q != IDLE);
    o_done      = done_q;
  end

  // Stage 0 sees the vector only on an accept; otherwise a zero bubble enters every row.
  logic [NUM_ROWS-1:0][MUL_DATAWIDTH:0] stage0;

  always_comb begin
    stage0 = '0;
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      if (accept) begin
        stage0[r] = {1'b1, i_act[r]};
      end
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [MUL_DATAWIDTH:0] row_q;

    sa_delay_line #(
      .WIDTH(MUL_DATAWIDTH + 1),
      .DEPTH(r + 1)
    ) u_delay (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (stage0[r]),
      .q_o   (row_q)
    );

    assign o_act[r]     = row_q[MUL_DATAWIDTH-1:0];
    assign o_act_vld[r] = row_q[MUL_DATAWIDTH];
  end

endmodule

// File: doc/sa_act_skew.md
Name: sa_act_skew

Overview:
- Activation feeder placed directly upstream of the systolic compute array (sa_compute) on its activation inputs.
- Accepts one unskewed activation vector (one element per array row) per cycle through a valid/ready handshake.
- Delays row r by r extra cycles so the array sees a diagonal wavefront. Inserts zero bubbles when input stalls.
- After the last vector, drains zeros so every result leaves the array, then signals completion.

Parameters:
MUL_DATAWIDTH, 8, activation element width (matches array multiplier width)
NUM_ROWS, 4, array rows = activation lanes
NUM_COLS, 4, array columns; used only for the drain length
CNT_W, 16, width of the vector-count field
DRAIN_CYCLES, NUM_ROWS+NUM_COLS-1, zero-injection cycles after the last accepted vector

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  start a tile; sampled only in IDLE
i_num_vec  in  CNT_W  vectors in tile; latched on accepted i_start
i_act_valid  in  1  i_act holds a valid vector
i_act  in  MUL_DATAWIDTH x [NUM_ROWS]  unskewed activation vector
o_act_ready  out  1  block accepts a vector this cycle
o_act  out  MUL_DATAWIDTH x [NUM_ROWS]  skewed activations to the array
o_act_vld  out  [NUM_ROWS]  per-row valid, skewed identically to o_act
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle tile-complete pulse

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all o_act and o_act_vld are 0; o_act_ready, o_busy and o_done are 0; state is IDLE; counters are 0.
- Reset mid-operation clears everything immediately, with no drain. A partial tile is discarded.
- Handshake: a vector is accepted when i_act_valid && o_act_ready. o_act_ready is a registered-state decode: 1 only in FEED.
- Skew pipeline:
  - A vector accepted in cycle t drives o_act[r] = i_act[r] and o_act_vld[r] = 1 in cycle t+1+r.
  - All outputs are registered. Row r holds a delay line of depth r+1.
  - The pipeline shifts every cycle in every state; there is no back-pressure from the array.
  - In any cycle without an accept, stage 0 of every row loads data 0 and vld 0. This gives bubbles in FEED and zero-fill in DRAIN/IDLE.
- FSM:
  - IDLE:
    - i_start with i_num_vec > 0: latch the count into vec_rem and go to FEED.
    - i_start with i_num_vec == 0: stay in IDLE and assert o_done in the next cycle.
  - FEED:
    - Each accept decrements vec_rem.
    - An accept with vec_rem == 1 goes to DRAIN and loads drain_cnt = DRAIN_CYCLES.
    - i_act_valid low holds the state and injects a bubble.
  - DRAIN:
    - o_act_ready = 0; drain_cnt decrements each cycle.
    - At drain_cnt == 1, go to IDLE and register o_done = 1 for the first IDLE cycle.
- Ignored inputs:
  - i_start outside IDLE is ignored, and i_num_vec is not re-latched.
  - i_act_valid outside FEED is ignored.
- i_start arriving in the same cycle as the o_done pulse (state IDLE) is honoured.
- Counters:
  - vec_rem is CNT_W bits; the maximum 2^CNT_W-1 vectors is supported; no wrap.
  - drain_cnt is $clog2(DRAIN_CYCLES+1) bits.
- Elaboration: NUM_ROWS >= 1 and DRAIN_CYCLES >= 1 are checked; violations are fatal.

Decomposition:
- Package sa_pkg holds:
  - typedef enum logic [1:0] {IDLE, FEED, DRAIN} skew_state_t
  - a localparam helper for the drain counter width
- Sub-module sa_delay_line (params WIDTH, DEPTH):
  - async-reset shift register carrying {vld, data}
  - instantiated once per row with DEPTH = r+1 in a generate loop
- The top level holds only the FSM, the counters and the stage-0 muxing.

Test Plan (NUM_ROWS=4, NUM_COLS=4, DRAIN_CYCLES=7, MUL_DATAWIDTH=8):
- Back-to-back tile: start with num_vec=2; A={1,2,3,4} accepted at cycle T, B={5,6,7,8} at T+1.
  -> o_act[0] = 1 at T+1 and 5 at T+2.
  -> o_act[3] = 4 at T+4 and 8 at T+5.
  -> All other samples are 0 with vld 0.
  -> DRAIN runs T+2..T+8; o_done = 1 and o_busy = 0 at T+9.
- Bubble: i_act_valid low for one cycle between A and B.
  -> o_act[0] sequence is 1, 0, 5 and o_act_vld[0] is 1, 0, 1.
  -> The same pattern appears on row 3 three cycles later.
  -> o_done is one cycle later than in the back-to-back case.
- Zero-length tile: i_start with num_vec=0.
  -> o_done pulses in the next cycle; o_busy and o_act_ready stay 0.
- Reset mid-FEED: assert rst_n low after A is accepted.
  -> All o_act, o_act_vld, o_act_ready and o_busy are 0 asynchronously, with no o_done.
  -> After release, a fresh tile behaves as in the back-to-back case.
- Start while busy: i_start with num_vec=9 during FEED of a num_vec=2 tile.
  -> Ignored; exactly 2 vectors are accepted and o_done fires once.
- Restart in done cycle: i_start asserted in the o_done cycle.
  -> FEED is entered in the next cycle with the new count.
